// File: rtl/lsq_request_arbiter_if.sv
// lsq_arb_if: bundle between the load/store OUs, the arbiter and the processor LSQ
//   unit_*  : per-unit request fields, strobes, back-pressure and load completion
//   lsq_*   : head request toward the LSQ, its handshake, and in-order load results
//   protocol_error : sticky flag for a load result with nothing outstanding
//   modport slave is the arbiter view, modport master the environment view
interface lsq_arb_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN = 32
);
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_addr;
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_data;
    logic [NUM_UNITS-1:0][2:0] unit_fn3;
    logic [NUM_UNITS-1:0] unit_load;
    logic [NUM_UNITS-1:0] unit_store;
    logic [NUM_UNITS-1:0] unit_new_request;
    logic [NUM_UNITS-1:0] unit_lsq_full;
    logic [NUM_UNITS-1:0] unit_load_complete;
    logic [XLEN-1:0] unit_load_data;
    logic [XLEN-1:0] lsq_addr;
    logic [XLEN-1:0] lsq_data;
    logic [2:0] lsq_fn3;
    logic lsq_load;
    logic lsq_store;
    logic lsq_valid;
    logic lsq_ready;
    logic [XLEN-1:0] lsq_load_data;
    logic lsq_load_valid;
    logic protocol_error;

    modport slave (
        input unit_addr, unit_data, unit_fn3, unit_load, unit_store, unit_new_request,
        input lsq_ready, lsq_load_data, lsq_load_valid,
        output unit_lsq_full, unit_load_complete, unit_load_data,
        output lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_valid, protocol_error
    );

    modport master (
        output unit_addr, unit_data, unit_fn3, unit_load, unit_store, unit_new_request,
        output lsq_ready, lsq_load_data, lsq_load_valid,
        input unit_lsq_full, unit_load_complete, unit_load_data,
        input lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store, lsq_valid, protocol_error
    );
endinterface

// File: rtl/lsq_request_arbiter.sv
// lsq_request_arbiter: round-robin slot arbiter sharing one LSQ port among load/store OUs
//   clk, rst : clock and asynchronous active-high reset
//   bus      : lsq_arb_if slave view (unit requests in, LSQ head out, load completions back)
module lsq_request_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int LOAD_TRACK_DEPTH = 4,
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    lsq_arb_if.slave bus
);
    localparam int UW = $clog2(NUM_UNITS);
    localparam int TW = $clog2(LOAD_TRACK_DEPTH);
    localparam int CW = TW + 1;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0] fn3;
        logic load;
        logic store;
        logic [UW-1:0] id;
    } req_t;

    req_t req_q [2];
    logic wr_ptr, rd_ptr;
    logic [1:0] req_count;
    logic [UW-1:0] slot_ptr;
    logic [UW-1:0] trk_q [LOAD_TRACK_DEPTH];
    logic [TW-1:0] trk_wr, trk_rd;
    logic [CW-1:0] trk_count;
    logic req_full, trk_full, accept, pop, trk_push, trk_pop;

    // Back-pressure depends on registers only, so units may derive their request from it.
    assign req_full = req_count == 2'd2;
    assign trk_full = trk_count == CW'(LOAD_TRACK_DEPTH);
    assign bus.unit_lsq_full = (req_full || trk_full) ? '1 : ~(NUM_UNITS'(1) << slot_ptr);
    assign accept = bus.unit_new_request[slot_ptr] && !req_full && !trk_full;
    assign pop = bus.lsq_valid && bus.lsq_ready;
    assign trk_push = accept && bus.unit_load[slot_ptr];
    assign trk_pop = bus.lsq_load_valid && trk_count != '0;

    assign bus.lsq_valid = req_count != 2'd0;
    assign bus.lsq_addr = req_q[rd_ptr].addr;
    assign bus.lsq_data = req_q[rd_ptr].data;
    assign bus.lsq_fn3 = req_q[rd_ptr].fn3;
    assign bus.lsq_load = req_q[rd_ptr].load;
    assign bus.lsq_store = req_q[rd_ptr].store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ptr <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            req_count <= '0;
            trk_wr <= '0;
            trk_rd <= '0;
            trk_count <= '0;
            for (int i = 0; i < 2; i++) req_q[i] <= '0;
            for (int i = 0; i < LOAD_TRACK_DEPTH; i++) trk_q[i] <= '0;
            bus.unit_load_complete <= '0;
            bus.unit_load_data <= '0;
            bus.protocol_error <= 1'b0;
        end else begin
            slot_ptr <= (slot_ptr == UW'(NUM_UNITS - 1)) ? '0 : slot_ptr + 1'b1;
            if (accept) begin
                req_q[wr_ptr] <= '{bus.unit_addr[slot_ptr], bus.unit_data[slot_ptr],
                                   bus.unit_fn3[slot_ptr], bus.unit_load[slot_ptr],
                                   bus.unit_store[slot_ptr], slot_ptr};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            req_count <= req_count + 2'(accept) - 2'(pop);
            if (trk_push) begin
                trk_q[trk_wr] <= slot_ptr;
                trk_wr <= trk_wr + 1'b1;
            end
            if (trk_pop) begin
                trk_rd <= trk_rd + 1'b1;
                bus.unit_load_data <= bus.lsq_load_data;
            end
            trk_count <= trk_count + CW'(trk_push) - CW'(trk_pop);
            bus.unit_load_complete <= trk_pop ? (NUM_UNITS'(1) << trk_q[trk_rd]) : '0;
            // A result with nothing outstanding (including loads discarded by reset) is an error.
            if (bus.lsq_load_valid && trk_count == '0) bus.protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsq_request_arbiter.sv
// tb_lsq_request_arbiter: table-driven check of slotting, buffering, load routing and errors
module tb_lsq_request_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsq_arb_if #(.NUM_UNITS(4), .XLEN(32)) bus ();
    lsq_request_arbiter #(.NUM_UNITS(4), .LOAD_TRACK_DEPTH(4), .XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] ld;
        logic rdy;
        logic lv;
        logic [31:0] ldata;
        logic vld;
        logic [31:0] addr;
        logic lload;
        logic [3:0] full;
        logic [3:0] cmp;
        logic [31:0] udata;
        logic perr;
    } vec_t;

    vec_t v[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, ld, input logic rdy, lv, input logic [31:0] ldata,
                       input logic vld, input logic [31:0] addr, input logic lload,
                       input logic [3:0] full, cmp, input logic [31:0] udata, input logic perr);
        v.push_back(vec_t'{req, ld, rdy, lv, ldata, vld, addr, lload, full, cmp, udata, perr});
    endtask

    task automatic drive(input logic [3:0] req, ld, input logic rdy, lv, input logic [31:0] ldata);
        bus.unit_new_request = req;
        bus.unit_load = ld;
        bus.unit_store = ~ld;
        bus.lsq_ready = rdy;
        bus.lsq_load_valid = lv;
        bus.lsq_load_data = ldata;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            bus.unit_addr[i] = 32'h100 + 32'(i * 16);
            bus.unit_data[i] = 32'hD0 + 32'(i);
            bus.unit_fn3[i] = 3'(i);
        end
        drive(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        // single load from unit 0, completion four cycles later
        add(4'h1, 4'h1, 1, 0, 0,            0, 0,      0, 4'hE, 4'h0, 0,            0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h100,  1, 4'hD, 4'h0, 0,            0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hB, 4'h0, 0,            0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'h7, 4'h0, 0,            0);
        add(4'h0, 4'h0, 1, 1, 'hDEADBEEF,   0, 0,      0, 4'hE, 4'h0, 0,            0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hD, 4'h1, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hB, 4'h0, 'hDEADBEEF,   0);
        // continuous stores from all units, then back-pressure with lsq_ready low
        add(4'hF, 4'h0, 1, 0, 0,            0, 0,      0, 4'h7, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'h0, 1, 0, 0,            1, 'h130,  0, 4'hE, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'h0, 1, 0, 0,            1, 'h100,  0, 4'hD, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'h0, 1, 0, 0,            1, 'h110,  0, 4'hB, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'h0, 0, 0, 0,            1, 'h120,  0, 4'h7, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'h0, 0, 0, 0,            1, 'h120,  0, 4'hF, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 0, 0, 0,            1, 'h120,  0, 4'hF, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h120,  0, 4'hF, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h130,  0, 4'h7, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hE, 4'h0, 'hDEADBEEF,   0);
        // loads from units 2,0,3,1 fill the tracker
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hD, 4'h0, 'hDEADBEEF,   0);
        add(4'h4, 4'h4, 1, 0, 0,            0, 0,      0, 4'hB, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h120,  1, 4'h7, 4'h0, 'hDEADBEEF,   0);
        add(4'h1, 4'h1, 1, 0, 0,            0, 0,      0, 4'hE, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h100,  1, 4'hD, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hB, 4'h0, 'hDEADBEEF,   0);
        add(4'h8, 4'h8, 1, 0, 0,            0, 0,      0, 4'h7, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 0, 0,            1, 'h130,  1, 4'hE, 4'h0, 'hDEADBEEF,   0);
        add(4'h2, 4'h2, 1, 0, 0,            0, 0,      0, 4'hD, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'hF, 1, 0, 0,            1, 'h110,  1, 4'hF, 4'h0, 'hDEADBEEF,   0);
        add(4'hF, 4'hF, 1, 1, 'h11110002,   0, 0,      0, 4'hF, 4'h0, 'hDEADBEEF,   0);
        add(4'h0, 4'h0, 1, 1, 'h22220000,   0, 0,      0, 4'hE, 4'h4, 'h11110002,   0);
        add(4'h0, 4'h0, 1, 1, 'h33330003,   0, 0,      0, 4'hD, 4'h1, 'h22220000,   0);
        add(4'h0, 4'h0, 1, 1, 'h44440001,   0, 0,      0, 4'hB, 4'h8, 'h33330003,   0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'h7, 4'h2, 'h44440001,   0);
        // load result with nothing outstanding
        add(4'h0, 4'h0, 1, 1, 'h5555,       0, 0,      0, 4'hE, 4'h0, 'h44440001,   0);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hD, 4'h0, 'h44440001,   1);
        add(4'h0, 4'h0, 1, 0, 0,            0, 0,      0, 4'hB, 4'h0, 'h44440001,   1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < v.size(); i++) begin
            chk($sformatf("r%0d vld", i), 32'(bus.lsq_valid), 32'(v[i].vld));
            if (v[i].vld) begin
                chk($sformatf("r%0d addr", i), bus.lsq_addr, v[i].addr);
                chk($sformatf("r%0d data", i), bus.lsq_data, 32'hD0 + ((v[i].addr - 32'h100) >> 4));
                chk($sformatf("r%0d fn3", i), 32'(bus.lsq_fn3), (v[i].addr - 32'h100) >> 4);
                chk($sformatf("r%0d load", i), 32'(bus.lsq_load), 32'(v[i].lload));
                chk($sformatf("r%0d store", i), 32'(bus.lsq_store), 32'(!v[i].lload));
            end
            chk($sformatf("r%0d full", i), 32'(bus.unit_lsq_full), 32'(v[i].full));
            chk($sformatf("r%0d cmp", i), 32'(bus.unit_load_complete), 32'(v[i].cmp));
            chk($sformatf("r%0d udata", i), bus.unit_load_data, v[i].udata);
            chk($sformatf("r%0d perr", i), 32'(bus.protocol_error), 32'(v[i].perr));
            drive(v[i].req, v[i].ld, v[i].rdy, v[i].lv, v[i].ldata);
            @(negedge clk);
        end

        // two loads outstanding (units 3 and 0), then asynchronous reset mid-cycle
        drive(4'hF, 4'hF, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        chk("pre_rst vld", 32'(bus.lsq_valid), 32'd1);
        chk("pre_rst addr", bus.lsq_addr, 32'h100);
        #2 rst = 1'b1;
        #1;
        chk("arst full", 32'(bus.unit_lsq_full), 32'hE);
        chk("arst vld", 32'(bus.lsq_valid), 32'd0);
        chk("arst addr", bus.lsq_addr, 32'h0);
        chk("arst data", bus.lsq_data, 32'h0);
        chk("arst fn3", 32'(bus.lsq_fn3), 32'd0);
        chk("arst load", 32'(bus.lsq_load), 32'd0);
        chk("arst store", 32'(bus.lsq_store), 32'd0);
        chk("arst cmp", 32'(bus.unit_load_complete), 32'd0);
        chk("arst udata", bus.unit_load_data, 32'h0);
        chk("arst perr", 32'(bus.protocol_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h0, 4'h0, 1'b1, 1'b1, 32'h77);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        chk("stale perr", 32'(bus.protocol_error), 32'd1);
        chk("stale cmp", 32'(bus.unit_load_complete), 32'd0);
        chk("stale udata", bus.unit_load_data, 32'h0);
        @(negedge clk);
        chk("sticky perr", 32'(bus.protocol_error), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsq_request_arbiter.md
# lsq_request_arbiter

Shared load/store port between the reconfigurable-region load/store OUs and the single processor LSQ. Each cycle it offers one OU a round-robin time-division slot and buffers accepted requests in a 2-entry FIFO toward the LSQ. It also records the owning unit of every accepted load and routes in-order load completions back to that unit. Every per-unit `lsq_full` is driven purely from registers, so an OU may combinationally derive `new_request` from it without creating a loop.

## Interface
Parameters:
- NUM_UNITS, default 4: number of attached load/store OUs, ≥2.
- LOAD_TRACK_DEPTH, default 4: maximum outstanding loads, power of two.
- XLEN comes from the processor config package (32).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- unit_addr  in  NUM_UNITS×XLEN  per-unit request address.
- unit_data  in  NUM_UNITS×XLEN  per-unit store data.
- unit_fn3  in  NUM_UNITS×3  per-unit access funct3.
- unit_load, unit_store  in  NUM_UNITS  per-unit request type; exactly one is set when a request is made.
- unit_new_request  in  NUM_UNITS  per-unit request strobe.
- unit_lsq_full  out  NUM_UNITS  per-unit back-pressure.
- unit_load_data  out  XLEN  load result, broadcast to all units.
- unit_load_complete  out  NUM_UNITS  one-hot load completion.
- lsq_addr, lsq_data  out  XLEN  head request fields.
- lsq_fn3  out  3  head request funct3.
- lsq_load, lsq_store  out  1  head request type.
- lsq_valid  out  1  head request present.
- lsq_ready  in  1  LSQ accepts the head request this cycle.
- lsq_load_data  in  XLEN  load result from the LSQ.
- lsq_load_valid  in  1  load result valid; results arrive in issue order.
- protocol_error  out  1  sticky error flag.

## Operation
- slot_ptr: log2(NUM_UNITS)-bit counter.
  - Increments every cycle unconditionally and wraps from NUM_UNITS-1 to 0.
  - Resets to 0.
- Request FIFO: 2 entries, holding {addr, data, fn3, load, store, unit_id}.
- Load tracker: FIFO of unit_id, LOAD_TRACK_DEPTH entries, with a count register that saturates at LOAD_TRACK_DEPTH.
- unit_lsq_full[i] = (i != slot_ptr) OR (req_count == 2) OR (trk_count == LOAD_TRACK_DEPTH).
  - The tracker-full term applies to stores as well (conservative choice).
  - The expression uses registered state only.
- Accept condition: unit_new_request[slot_ptr] && !unit_lsq_full[slot_ptr].
  - On accept, the unit's fields plus unit_id = slot_ptr are pushed into the request FIFO.
  - If unit_load is set, slot_ptr is also pushed into the load tracker in the same cycle.
  - unit_new_request from a unit whose unit_lsq_full is high is ignored.
- LSQ side:
  - lsq_valid = (req_count != 0).
  - lsq_* outputs are driven from the FIFO head.
  - The head pops when lsq_valid && lsq_ready.
  - Push and pop in the same cycle leave req_count unchanged.
- Completion on lsq_load_valid with trk_count > 0:
  - Pop the tracker head.
  - Next cycle, drive unit_load_complete = one-hot(head id) for exactly one cycle and unit_load_data = registered lsq_load_data.
  - A tracker push and pop in the same cycle leave trk_count unchanged; a push into a full tracker cannot occur because full blocks accept.
- Error on lsq_load_valid with trk_count == 0:
  - Set protocol_error; it stays set until reset.
  - No completion is generated.
- Width rule: unit_id is log2(NUM_UNITS) bits; all FIFO pointers wrap modulo their depth.

## Timing
- Reset values:
  - unit_lsq_full: all 1 except bit 0, which is 0.
  - lsq_valid 0; lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store all 0.
  - unit_load_complete 0; unit_load_data 0; protocol_error 0.
  - All counters and pointers 0.
- Request latency: accept in cycle N gives lsq_valid in cycle N+1 at the earliest.
- Slot wait: a unit waits at most NUM_UNITS-1 cycles for its slot.
- Completion latency: lsq_load_valid in cycle M gives unit_load_complete in cycle M+1.
- Handshake hold: lsq_* outputs hold stable while lsq_valid && !lsq_ready.
- Simultaneous events: accept, LSQ pop, tracker pop and completion may all occur in one cycle, with no stall or loss.
- Reset mid-operation:
  - All buffered requests and tracked loads are discarded.
  - A later lsq_load_valid from a stale load sets protocol_error.

## Test plan
- After reset, unit 0 requests a load at address 0x100 in cycle 0 with lsq_ready=1 → lsq_valid=1 with lsq_addr=0x100 and lsq_load=1 in cycle 1. Then lsq_load_valid=1 with data 0xDEAD_BEEF in cycle 4 → unit_load_complete=4'b0001 and unit_load_data=0xDEADBEEF in cycle 5.
- All four units request continuously, with lsq_ready=1 → LSQ sees unit order 0,1,2,3,0… at one request per cycle; every unit_lsq_full bit is 1 outside that unit's slot.
- lsq_ready=0 while two requests are buffered → req_count=2, every unit_lsq_full bit is 1, and lsq_addr holds stable. Raising lsq_ready drains one request per cycle.
- Four loads issued by units 2,0,3,1 → tracker full blocks all units. Four in-order completions assert unit_load_complete bits 2,0,3,1 in that order, and unit_lsq_full for the slot-holder drops after the first completion.
- lsq_load_valid with nothing outstanding → protocol_error=1 and no unit_load_complete. The flag stays high until rst is asserted.
- rst asserted asynchronously with two loads outstanding → all outputs take reset values immediately. A stale lsq_load_valid after reset sets protocol_error.
